// File: rtl/instr_encoder_loader_if.sv
// Instruction-field channel from the boot host into the encoder/loader.
// The host drives the fields and valid/last; the loader answers with ready.
interface instr_encoder_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [4:0]  mnem;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  shamt;
    logic [25:0] imm;

    modport master (output in_valid, in_last, mnem, rs, rt, shamt, imm,
                    input  in_ready);
    modport slave  (input  in_valid, in_last, mnem, rs, rt, shamt, imm,
                    output in_ready);
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes mnemonic-level fields into KGP-miniRISC words and writes them
// sequentially into instruction memory, one word per two cycles.
module instr_encoder_loader #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_start,
    instr_encoder_loader_if.slave  instr,
    output logic                   imem_we,
    output logic [ADDR_W-1:0]      imem_addr,
    output logic [31:0]            imem_wdata,
    output logic                   load_done,
    output logic [ADDR_W:0]        word_count,
    output logic                   err_illegal,
    output logic                   err_full
);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;
    typedef enum logic [2:0] {F_R, F_RI, F_RRI, F_BR, F_J} fmt_t;

    state_t      state;
    logic        last_q;
    logic [5:0]  op;
    logic [5:0]  func;
    fmt_t        fmt;
    logic        legal;
    logic [31:0] enc_word;

    always_comb begin
        op    = '0;
        func  = '0;
        fmt   = F_R;
        legal = 1'b1;
        case (instr.mnem)
            5'd0:  begin op = 6'd0;  func = 6'd0; fmt = F_R;   end
            5'd1:  begin op = 6'd0;  func = 6'd1; fmt = F_R;   end
            5'd2:  begin op = 6'd1;  fmt = F_RI;  end
            5'd3:  begin op = 6'd2;  fmt = F_RI;  end
            5'd4:  begin op = 6'd3;  func = 6'd0; fmt = F_R;   end
            5'd5:  begin op = 6'd3;  func = 6'd1; fmt = F_R;   end
            5'd6:  begin op = 6'd4;  func = 6'd0; fmt = F_R;   end
            5'd7:  begin op = 6'd4;  func = 6'd1; fmt = F_R;   end
            5'd8:  begin op = 6'd4;  func = 6'd2; fmt = F_R;   end
            5'd9:  begin op = 6'd4;  func = 6'd3; fmt = F_R;   end
            5'd10: begin op = 6'd4;  func = 6'd4; fmt = F_R;   end
            5'd11: begin op = 6'd4;  func = 6'd5; fmt = F_R;   end
            5'd12: begin op = 6'd5;  fmt = F_RRI; end
            5'd13: begin op = 6'd6;  fmt = F_RRI; end
            5'd14: begin op = 6'd7;  fmt = F_RI;  end
            5'd15: begin op = 6'd8;  fmt = F_RI;  end
            5'd16: begin op = 6'd9;  fmt = F_RI;  end
            5'd17: begin op = 6'd10; fmt = F_BR;  end
            5'd18: begin op = 6'd11; fmt = F_J;   end
            5'd19: begin op = 6'd12; fmt = F_J;   end
            5'd20: begin op = 6'd13; fmt = F_J;   end
            5'd21: begin op = 6'd14; fmt = F_J;   end
            5'd22: begin op = 6'd15; func = 6'd0; fmt = F_R;   end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        enc_word = '0;
        case (fmt)
            F_R:     enc_word = {op, instr.rs, instr.rt, instr.shamt, 5'd0, func};
            F_RI:    enc_word = {op, instr.rs, 5'd0, instr.imm[15:0]};
            F_RRI:   enc_word = {op, instr.rs, instr.rt, instr.imm[15:0]};
            F_BR:    enc_word = {op, instr.rs, 21'd0};
            F_J:     enc_word = {op, instr.imm};
            default: enc_word = '0;
        endcase
    end

    // Full is word_count == 2^ADDR_W; the count never exceeds that, so the MSB suffices.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            last_q      <= 1'b0;
            instr.in_ready <= 1'b0;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            load_done   <= 1'b0;
            word_count  <= '0;
            err_illegal <= 1'b0;
            err_full    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    load_done <= 1'b0;
                    if (load_start) begin
                        state          <= LOAD;
                        instr.in_ready <= 1'b1;
                        imem_addr      <= '0;
                        word_count     <= '0;
                        err_illegal    <= 1'b0;
                        err_full       <= 1'b0;
                    end
                end
                LOAD: begin
                    if (instr.in_valid) begin
                        if (!legal || word_count[ADDR_W]) begin
                            if (!legal) err_illegal <= 1'b1;
                            else        err_full    <= 1'b1;
                            if (instr.in_last) begin
                                state          <= DONE;
                                instr.in_ready <= 1'b0;
                                load_done      <= 1'b1;
                            end
                        end else begin
                            state          <= WRITE;
                            instr.in_ready <= 1'b0;
                            imem_we        <= 1'b1;
                            imem_wdata     <= enc_word;
                            last_q         <= instr.in_last;
                        end
                    end
                end
                WRITE: begin
                    imem_we    <= 1'b0;
                    word_count <= word_count + 1'b1;
                    // Hold the address at the top word rather than wrapping to 0.
                    if (imem_addr != '1) imem_addr <= imem_addr + 1'b1;
                    if (last_q) begin
                        state     <= DONE;
                        load_done <= 1'b1;
                    end else begin
                        state          <= LOAD;
                        instr.in_ready <= 1'b1;
                    end
                end
                DONE: begin
                    load_done <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench: ADDR_W=10 instance for encoding/flow, ADDR_W=2 instance for capacity.
module tb_instr_encoder_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic        valid = 1'b0, last = 1'b0;
    logic [4:0]  f_mnem = '0, f_rs = '0, f_rt = '0, f_shamt = '0;
    logic [25:0] f_imm = '0;

    int checks = 0;
    int errors = 0;

    instr_encoder_loader_if ifa ();
    instr_encoder_loader_if ifb ();

    assign ifa.in_valid = valid;  assign ifb.in_valid = valid;
    assign ifa.in_last  = last;   assign ifb.in_last  = last;
    assign ifa.mnem     = f_mnem; assign ifb.mnem     = f_mnem;
    assign ifa.rs       = f_rs;   assign ifb.rs       = f_rs;
    assign ifa.rt       = f_rt;   assign ifb.rt       = f_rt;
    assign ifa.shamt    = f_shamt; assign ifb.shamt   = f_shamt;
    assign ifa.imm      = f_imm;  assign ifb.imm      = f_imm;

    logic        we_a, done_a, ill_a, full_a;
    logic [9:0]  addr_a;
    logic [31:0] data_a;
    logic [10:0] cnt_a;
    logic        we_b, done_b, ill_b, full_b;
    logic [1:0]  addr_b;
    logic [31:0] data_b;
    logic [2:0]  cnt_b;

    instr_encoder_loader #(.ADDR_W(10)) dut_a (
        .clk(clk), .rst(rst), .load_start(start_a), .instr(ifa),
        .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(data_a),
        .load_done(done_a), .word_count(cnt_a),
        .err_illegal(ill_a), .err_full(full_a));

    instr_encoder_loader #(.ADDR_W(2)) dut_b (
        .clk(clk), .rst(rst), .load_start(start_b), .instr(ifb),
        .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(data_b),
        .load_done(done_b), .word_count(cnt_b),
        .err_illegal(ill_b), .err_full(full_b));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? ifb.in_ready : ifa.in_ready;
    endfunction

    // Entered just after a negedge; returns at the negedge following the transfer edge.
    task automatic pulse_start(input bit sel);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic send(input bit sel, input logic [4:0] m, input logic [4:0] s,
                        input logic [4:0] t, input logic [4:0] sh,
                        input logic [25:0] im, input logic l);
        int n;
        f_mnem = m; f_rs = s; f_rt = t; f_shamt = sh; f_imm = im; last = l;
        valid = 1'b1;
        n = 0;
        while (!rdy(sel) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {31'd0, rdy(sel)}, 32'd1);
        @(negedge clk);
        valid = 1'b0;
        last  = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, ifa.in_ready}, 32'd0);
        chk("rst_we", {31'd0, we_a}, 32'd0);
        chk("rst_addr", {22'd0, addr_a}, 32'd0);
        chk("rst_wdata", data_a, 32'd0);
        chk("rst_done", {31'd0, done_a}, 32'd0);
        chk("rst_count", {21'd0, cnt_a}, 32'd0);
        chk("rst_errs", {30'd0, ill_a, full_a}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single add with last
        pulse_start(0);
        chk("load_ready", {31'd0, ifa.in_ready}, 32'd1);
        send(0, 5'd0, 5'd1, 5'd2, 5'd0, 26'd0, 1'b1);
        chk("add_we", {31'd0, we_a}, 32'd1);
        chk("add_addr", {22'd0, addr_a}, 32'd0);
        chk("add_data", data_a, 32'h0022_0000);
        @(negedge clk);
        chk("add_done", {31'd0, done_a}, 32'd1);
        chk("add_we_off", {31'd0, we_a}, 32'd0);
        chk("add_count", {21'd0, cnt_a}, 32'd1);
        @(negedge clk);
        chk("add_done_pulse", {31'd0, done_a}, 32'd0);
        chk("idle_ready", {31'd0, ifa.in_ready}, 32'd0);

        // Three-word program
        pulse_start(0);
        send(0, 5'd2, 5'd3, 5'd0, 5'd0, 26'h000FFFF, 1'b0);
        chk("addi_addr", {22'd0, addr_a}, 32'd0);
        chk("addi_data", data_a, 32'h0460_FFFF);
        @(negedge clk);
        chk("mid_count", {21'd0, cnt_a}, 32'd1);
        chk("mid_ready", {31'd0, ifa.in_ready}, 32'd1);
        send(0, 5'd13, 5'd4, 5'd5, 5'd0, 26'd8, 1'b0);
        chk("sw_addr", {22'd0, addr_a}, 32'd1);
        chk("sw_data", data_a, 32'h1885_0008);
        @(negedge clk);
        send(0, 5'd10, 5'd7, 5'd0, 5'd3, 26'd0, 1'b1);
        chk("shra_addr", {22'd0, addr_a}, 32'd2);
        chk("shra_data", data_a, 32'h10E0_1804);
        @(negedge clk);
        chk("three_done", {31'd0, done_a}, 32'd1);
        chk("three_count", {21'd0, cnt_a}, 32'd3);
        @(negedge clk);

        // Jump-format and br, with a load_start ignored mid-load
        pulse_start(0);
        send(0, 5'd19, 5'd0, 5'd0, 5'd0, 26'h0000040, 1'b0);
        chk("bl_data", data_a, 32'h3000_0040);
        chk("write_ready_low", {31'd0, ifa.in_ready}, 32'd0);
        @(negedge clk);
        pulse_start(0);
        send(0, 5'd17, 5'd31, 5'd0, 5'd0, 26'd0, 1'b1);
        chk("br_addr", {22'd0, addr_a}, 32'd1);
        chk("br_data", data_a, 32'h2BE0_0000);
        @(negedge clk);
        chk("br_done", {31'd0, done_a}, 32'd1);
        @(negedge clk);

        // Illegal mnemonic between legal words
        pulse_start(0);
        send(0, 5'd0, 5'd1, 5'd2, 5'd0, 26'd0, 1'b0);
        chk("ill_w0_addr", {22'd0, addr_a}, 32'd0);
        @(negedge clk);
        send(0, 5'd25, 5'd1, 5'd1, 5'd1, 26'd1, 1'b0);
        chk("ill_no_we", {31'd0, we_a}, 32'd0);
        chk("ill_flag", {31'd0, ill_a}, 32'd1);
        chk("ill_stay_load", {31'd0, ifa.in_ready}, 32'd1);
        send(0, 5'd5, 5'd2, 5'd3, 5'd0, 26'd0, 1'b1);
        chk("xor_addr", {22'd0, addr_a}, 32'd1);
        chk("xor_data", data_a, 32'h0C43_0001);
        @(negedge clk);
        chk("ill_done", {31'd0, done_a}, 32'd1);
        chk("ill_count", {21'd0, cnt_a}, 32'd2);
        chk("ill_sticky", {31'd0, ill_a}, 32'd1);
        @(negedge clk);

        // Illegal mnemonic flagged last ends the load
        pulse_start(0);
        chk("ill_cleared", {31'd0, ill_a}, 32'd0);
        send(0, 5'd31, 5'd0, 5'd0, 5'd0, 26'd0, 1'b1);
        chk("ill_last_done", {31'd0, done_a}, 32'd1);
        chk("ill_last_count", {21'd0, cnt_a}, 32'd0);
        @(negedge clk);

        // Capacity on the ADDR_W=2 instance
        pulse_start(1);
        for (int i = 0; i < 4; i++) begin
            send(1, 5'd3, 5'(i), 5'd0, 5'd0, 26'(i * 17), 1'b0);
            chk("cap_we", {31'd0, we_b}, 32'd1);
            chk("cap_addr", {30'd0, addr_b}, 32'(i));
            chk("cap_data", data_b, (32'd2 << 26) | (32'(i) << 21) | 32'(i * 17));
            @(negedge clk);
        end
        chk("cap_count4", {29'd0, cnt_b}, 32'd4);
        chk("cap_no_wrap", {30'd0, addr_b}, 32'd3);
        send(1, 5'd0, 5'd1, 5'd2, 5'd0, 26'd0, 1'b1);
        chk("cap_discard", {31'd0, we_b}, 32'd0);
        chk("cap_full", {31'd0, full_b}, 32'd1);
        chk("cap_done", {31'd0, done_b}, 32'd1);
        chk("cap_count_final", {29'd0, cnt_b}, 32'd4);
        @(negedge clk);

        // Reset during WRITE
        pulse_start(0);
        send(0, 5'd0, 5'd1, 5'd2, 5'd0, 26'd0, 1'b0);
        chk("pre_rst_we", {31'd0, we_a}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_w_we", {31'd0, we_a}, 32'd0);
        chk("rst_w_ready", {31'd0, ifa.in_ready}, 32'd0);
        chk("rst_w_addr", {22'd0, addr_a}, 32'd0);
        chk("rst_w_wdata", data_a, 32'd0);
        chk("rst_w_count", {21'd0, cnt_a}, 32'd0);
        chk("rst_w_done", {31'd0, done_a}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        pulse_start(0);
        send(0, 5'd13, 5'd4, 5'd5, 5'd0, 26'd8, 1'b1);
        chk("restart_addr", {22'd0, addr_a}, 32'd0);
        chk("restart_data", data_a, 32'h1885_0008);
        @(negedge clk);
        chk("restart_count", {21'd0, cnt_a}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
